// File: rtl/perf_event_counter.sv
// Performance monitor: counts run cycles and per-cycle event strobes
// while the CPU runs, and stops itself after a programmable cycle budget.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset
//   start_i    run enable shared with the CPU; low in RUN pauses counting
//   evt_i      one event strobe per channel, sampled every clock
//   clr_i      synchronous clear of live counters, ovf flags and FSM
//   snap_i     copy live counters into the shadow registers
//   rd_sel_i   shadow select: 0..NUM_EVT-1 event channel, 15 cycle counter
//   rd_data_o  registered shadow read data
//   cycle_o    live cycle count
//   ovf_o      sticky overflow flags; bit NUM_EVT is the cycle counter
//   running_o  FSM in RUN
//   done_o     FSM in DONE
module perf_event_counter #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 70,
    parameter int SAT_MODE   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               clr_i,
    input  logic               snap_i,
    input  logic [3:0]         rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               running_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    // Index NUM_EVT of the counter arrays is the cycle counter.
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt   [NUM_EVT+1];
    logic [CNT_W-1:0] cnt_n [NUM_EVT+1];
    logic [CNT_W-1:0] sh    [NUM_EVT+1];
    logic [NUM_EVT:0] ovf, ovf_n;
    logic [NUM_EVT:0] hit;
    logic [CNT_W-1:0] rd_word;
    logic             en;

    assign en  = (state == RUN) && start_i;
    assign hit = en ? {1'b1, evt_i} : '0;

    always_comb begin
        ovf_n = ovf;
        for (int k = 0; k <= NUM_EVT; k++) begin
            cnt_n[k] = cnt[k];
            if (hit[k]) begin
                if (&cnt[k]) begin
                    ovf_n[k] = 1'b1;
                    cnt_n[k] = (SAT_MODE != 0) ? cnt[k] : '0;
                end else begin
                    cnt_n[k] = cnt[k] + ONE;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start_i) state_n = RUN;
            RUN: begin
                if ((MAX_CYCLES != 0) && en &&
                    (cnt_n[NUM_EVT] == MAX_C))
                    state_n = DONE;
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (clr_i) state_n = IDLE;
    end

    // The cycle select is checked last so it wins when NUM_EVT is 16.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rd_sel_i == 4'(k)) rd_word = sh[k];
        end
        if (rd_sel_i == 4'd15) rd_word = sh[NUM_EVT];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            ovf       <= '0;
            rd_data_o <= '0;
            for (int k = 0; k <= NUM_EVT; k++) begin
                cnt[k] <= '0;
                sh[k]  <= '0;
            end
        end else begin
            state     <= state_n;
            rd_data_o <= rd_word;
            // Shadows take the pre-edge live values, even on a clear.
            if (snap_i) begin
                for (int k = 0; k <= NUM_EVT; k++) sh[k] <= cnt[k];
            end
            if (clr_i) begin
                ovf <= '0;
                for (int k = 0; k <= NUM_EVT; k++) cnt[k] <= '0;
            end else begin
                ovf <= ovf_n;
                for (int k = 0; k <= NUM_EVT; k++) cnt[k] <= cnt_n[k];
            end
        end
    end

    assign cycle_o   = cnt[NUM_EVT];
    assign ovf_o     = ovf;
    assign running_o = (state == RUN);
    assign done_o    = (state == DONE);

endmodule

// File: doc/perf_event_counter.md
# perf_event_counter

Synthesizable performance-monitor block for the pipelined CPU. It counts run cycles plus NUM_EVT per-cycle event strobes, such as hazard-unit stall and IF-stage flush, in hardware. It stops itself after a programmable cycle budget and exposes counts through a snapshot/readout port. It sits beside the CPU top level and is driven by the same clock and start signal, so stall and flush statistics no longer need bench-side counting.

## Interface
- NUM_EVT, 4: number of event channels (1..16).
- CNT_W, 32: width of every event counter and the cycle counter (8..32).
- MAX_CYCLES, 70: cycle budget; 0 means no limit.
- SAT_MODE, 1: 1 = counters saturate at all-ones; 0 = counters wrap to 0.
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: reset, asynchronous, active-low.
- start_i, input, 1: run enable (same signal as the CPU start); counting occurs only while high.
- evt_i, input, NUM_EVT: event strobes, one bit per channel, sampled every clock.
- clr_i, input, 1: synchronous clear of all live counters, sticky flags and the FSM.
- snap_i, input, 1: copy all live counters into shadow registers.
- rd_sel_i, input, 4: shadow select; 0..NUM_EVT-1 = event channel, 15 = cycle counter, others read 0.
- rd_data_o, output, CNT_W: registered shadow read data.
- cycle_o, output, CNT_W: live cycle count.
- ovf_o, output, NUM_EVT+1: sticky overflow flags; bit NUM_EVT belongs to the cycle counter.
- running_o, output, 1: FSM in RUN.
- done_o, output, 1: FSM in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start_i = 1.
  - RUN -> DONE on the edge where the cycle counter becomes MAX_CYCLES (only when MAX_CYCLES != 0).
  - Any state -> IDLE when clr_i = 1.
  - DONE holds until clr_i.
- The count enable is asserted only when the state is RUN and start_i = 1. When start_i drops in RUN, the FSM stays in RUN and all counts freeze (pause).
- While enabled:
  - The cycle counter increments by 1 each clock.
  - Event counter k increments by 1 each clock in which evt_i[k] = 1.
- Width rule: a counter at all-ones that receives an increment sets its ovf_o bit (sticky), then:
  - SAT_MODE = 1: holds all-ones.
  - SAT_MODE = 0: wraps to 0.
- In DONE and IDLE, evt_i is ignored.
- Snapshot: snap_i = 1 loads every shadow with the live value present before that edge, so any increment on the same edge is excluded.
- clr_i and snap_i together: the shadow captures the pre-clear values, and the live counters, ovf_o and FSM clear. Shadows are cleared only by rst_i.
- clr_i has priority over counting and over the RUN -> DONE transition.

## Timing
- Reset (rst_i = 0, asynchronous) forces:
  - all counters, shadows and ovf_o = 0;
  - rd_data_o = 0;
  - state IDLE, running_o = 0, done_o = 0.
- Reset deassertion mid-run restarts in IDLE. No count survives reset.
- Counting latency: an event sampled at edge n is visible on cycle_o or in the live counter after edge n. It appears in rd_data_o only after a later snap_i edge plus 1 cycle.
- Read latency: rd_data_o reflects rd_sel_i and the shadow contents one clock after they are presented.
- IDLE -> RUN costs one edge: start_i rising before edge 0 gives running_o = 1 after edge 0, and the first count happens at edge 1.
- done_o asserts on the same edge on which cycle_o reaches MAX_CYCLES. No further increments occur afterwards.
- running_o and done_o are state decodes and are never high together.

## Test plan
- **Reset/idle:** rst_i low, then release with start_i = 0 and evt_i = all-ones for 10 cycles. Required: all outputs 0, running_o = 0.
- **Budget stop:** start_i = 1, evt_i[0] = 1 every cycle, evt_i[1] = 1 on alternating cycles. Required: done_o after cycle_o = 70; snapshot reads ch0 = 70, ch1 = 35, sel 15 = 70; further events do not change any count.
- **Pause:** start_i low for 5 cycles mid-run. Required: counts frozen during the pause; done_o arrives 5 cycles later than in the Budget stop scenario.
- **Saturate/wrap:** CNT_W = 8, MAX_CYCLES = 0, evt_i[2] = 1 for 300 cycles. Required: SAT_MODE = 1 gives 255 with ovf_o[2] = 1; SAT_MODE = 0 gives 300 mod 256 = 44 with ovf_o[2] = 1.
- **Snap/clear collision:** with ch0 = 20, assert snap_i, clr_i and evt_i[0] in the same cycle. Required: shadow ch0 = 20, live ch0 = 0, state IDLE, rd_data_o = 20 one cycle after rd_sel_i = 0.
- **Async reset mid-run:** drop rst_i between clock edges at cycle 30. Required: outputs clear immediately without waiting for an edge; the block restarts from IDLE after release.
